// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: single outstanding imem read, small FIFO to decode, redirect flush.
// Define FETCH_PERF_EN to add the perf_stall_cnt port (decode-starved cycle counter).
module fetch_ctrl #(
  parameter int DEPTH = 2,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] pc,
  output logic [AW-1:0] pc_next,
  output logic          pc_write,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [DW-1:0] imem_rdata,
  input  logic          redirect_valid,
  input  logic [AW-1:0] redirect_target,
  output logic          inst_valid,
  input  logic          inst_ready,
  output logic [DW-1:0] inst_data,
  output logic [AW-1:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]   perf_stall_cnt
`endif
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DW-1:0] mem_data [DEPTH];
  logic [AW-1:0] mem_pc   [DEPTH];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;

  logic          req_d;
  logic [AW-1:0] addr_d;
  logic          push;
  logic          pop;
  logic          flush;
  logic          pcw_raw;
  logic [AW-1:0] pcn_raw;

  assign inst_valid = (count != '0);
  assign inst_data  = mem_data[rptr];
  assign inst_pc    = mem_pc[rptr];
  assign pop        = inst_valid & inst_ready & ~flush;

  // PC load is combinational so the PC register holds the new value
  // in the cycle after ack, when IDLE samples it for the next request.
  assign pc_write = pcw_raw & ~reset;
  assign pc_next  = reset ? '0 : pcn_raw;

  always_comb begin
    state_d = state_q;
    req_d   = imem_req;
    addr_d  = imem_addr;
    pcw_raw = 1'b0;
    pcn_raw = '0;
    push    = 1'b0;
    flush   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pcw_raw = 1'b1;
          pcn_raw = redirect_target;
        end else if (count < CW'(DEPTH)) begin
          addr_d  = pc;
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pcw_raw = 1'b1;
          pcn_raw = redirect_target;
          if (imem_ack) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end else begin
            state_d = DRAIN;
          end
        end else if (imem_ack) begin
          push    = 1'b1;
          pcw_raw = 1'b1;
          pcn_raw = imem_addr + AW'(4);
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      DRAIN: begin
        if (redirect_valid) begin
          flush   = 1'b1;
          pcw_raw = 1'b1;
          pcn_raw = redirect_target;
        end
        if (imem_ack) begin
          req_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
    end else begin
      state_q   <= state_d;
      imem_req  <= req_d;
      imem_addr <= addr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wptr] <= imem_rdata;
      mem_pc[wptr]   <= imem_addr;
    end
  end

  // Flush wins over push/pop; push into a full FIFO only happens with a pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_cnt <= '0;
    end else if (!inst_valid && inst_ready && (perf_stall_cnt != '1)) begin
      perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: per-cycle vector table plus reset/stray-ack sequence.
// Build with FETCH_PERF_EN to also check perf_stall_cnt.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // External PC register driven by the controller
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pc <= '0;
    else if (pc_write) pc <= pc_next;
  end

  fetch_ctrl #(.DEPTH(2), .AW(32), .DW(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .pc              (pc),
    .pc_next         (pc_next),
    .pc_write        (pc_write),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .inst_valid      (inst_valid),
    .inst_ready      (inst_ready),
    .inst_data       (inst_data),
    .inst_pc         (inst_pc)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  typedef struct {
    logic        rdy;
    logic        ack;
    logic [31:0] rdata;
    logic        redir;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr;
    logic        pcw;
    logic [31:0] pcn;
    logic        iv;
    logic [31:0] ipc;
    logic [31:0] idata;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rdy, input logic ack, input logic [31:0] rdata,
                     input logic redir, input logic [31:0] tgt,
                     input logic req, input logic [31:0] addr,
                     input logic pcw, input logic [31:0] pcn,
                     input logic iv, input logic [31:0] ipc,
                     input logic [31:0] idata);
    vec_t v;
    v.rdy = rdy; v.ack = ack; v.rdata = rdata; v.redir = redir; v.tgt = tgt;
    v.req = req; v.addr = addr; v.pcw = pcw; v.pcn = pcn;
    v.iv = iv; v.ipc = ipc; v.idata = idata;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h, want %h", nm, idx, act, exp);
    end
  endtask

  initial begin
    reset           = 1'b1;
    imem_ack        = 1'b0;
    imem_rdata      = '0;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    inst_ready      = 1'b0;

    //  rdy ack rdata         rd tgt           req addr          pcw pcn           iv ipc           idata
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 32'hA000_0000, 0, 32'h0,       1, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hA000_0000);
    add(0, 1, 32'hA000_0001, 0, 32'h0,       1, 32'h4,        1, 32'h8,        1, 32'h0,        32'hA000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        0, 32'h0,        1, 32'h0,        32'hA000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        0, 32'h0,        1, 32'h0,        32'hA000_0000);
    add(1, 0, 32'h0,        0, 32'h0,        0, 32'h4,        0, 32'h0,        1, 32'h0,        32'hA000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h4,        0, 32'h0,        1, 32'h4,        32'hA000_0001);
    add(1, 1, 32'hA000_0002, 0, 32'h0,       1, 32'h8,        1, 32'hC,        1, 32'h4,        32'hA000_0001);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h8,        0, 32'h0,        1, 32'h8,        32'hA000_0002);
    add(0, 0, 32'h0,        1, 32'h100,      1, 32'hC,        1, 32'h100,      1, 32'h8,        32'hA000_0002);
    add(1, 0, 32'h0,        1, 32'h100,      1, 32'hC,        1, 32'h100,      0, 32'h0,        32'h0);
    add(0, 1, 32'hDEAD_BEEF, 0, 32'h0,       1, 32'hC,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'hC,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 32'hB000_0000, 0, 32'h0,       1, 32'h100,      1, 32'h104,      0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h100,      0, 32'h0,        1, 32'h100,      32'hB000_0000);
    add(0, 1, 32'hC000_0000, 1, 32'h200,     1, 32'h104,      1, 32'h200,      1, 32'h100,      32'hB000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h104,      0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        1, 32'hFFFF_FFFC, 1, 32'h200,     1, 32'hFFFF_FFFC, 0, 32'h0,       32'h0);
    add(0, 1, 32'hBAD0_BAD0, 0, 32'h0,       1, 32'h200,      0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 0, 32'h0,        0, 32'h0,        0, 32'h200,      0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 32'hD000_0000, 0, 32'h0,       1, 32'hFFFF_FFFC, 1, 32'h0,       0, 32'h0,        32'h0);
    add(1, 0, 32'h0,        0, 32'h0,        0, 32'hFFFF_FFFC, 0, 32'h0,       1, 32'hFFFF_FFFC, 32'hD000_0000);
    add(1, 0, 32'h0,        0, 32'h0,        1, 32'h0,        0, 32'h0,        0, 32'h0,        32'h0);
    add(0, 1, 32'hE000_0000, 0, 32'h0,       1, 32'h0,        1, 32'h4,        0, 32'h0,        32'h0);
    add(0, 1, 32'h1234_5678, 0, 32'h0,       0, 32'h0,        0, 32'h0,        1, 32'h0,        32'hE000_0000);
    add(0, 0, 32'h0,        0, 32'h0,        1, 32'h4,        0, 32'h0,        1, 32'h0,        32'hE000_0000);

    repeat (2) @(negedge clk);
    #1;
    chk("rst_req",   0, imem_req,   1'b0);
    chk("rst_addr",  0, imem_addr,  32'h0);
    chk("rst_pcw",   0, pc_write,   1'b0);
    chk("rst_pcn",   0, pc_next,    32'h0);
    chk("rst_valid", 0, inst_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk("rst_perf",  0, perf_stall_cnt, 32'h0);
`endif
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      inst_ready      = vq[i].rdy;
      imem_ack        = vq[i].ack;
      imem_rdata      = vq[i].rdata;
      redirect_valid  = vq[i].redir;
      redirect_target = vq[i].tgt;
      #1;
      chk("req",   i, imem_req,   vq[i].req);
      chk("addr",  i, imem_addr,  vq[i].addr);
      chk("pcw",   i, pc_write,   vq[i].pcw);
      if (vq[i].pcw) chk("pcn", i, pc_next, vq[i].pcn);
      chk("valid", i, inst_valid, vq[i].iv);
      if (vq[i].iv) begin
        chk("ipc",   i, inst_pc,   vq[i].ipc);
        chk("idata", i, inst_data, vq[i].idata);
      end
      @(negedge clk);
    end

    // Reset in the middle of an outstanding request
    imem_ack       = 1'b0;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_req",   0, imem_req,   1'b0);
    chk("mid_rst_addr",  0, imem_addr,  32'h0);
    chk("mid_rst_valid", 0, inst_valid, 1'b0);
    chk("mid_rst_pcw",   0, pc_write,   1'b0);
`ifdef FETCH_PERF_EN
    chk("mid_rst_perf",  0, perf_stall_cnt, 32'h0);
`endif
    @(negedge clk);
    reset      = 1'b0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hF00D_F00D;
    #1;
    chk("stray_pcw", 0, pc_write, 1'b0);
    chk("stray_req", 0, imem_req, 1'b0);
    @(negedge clk);
    imem_ack   = 1'b0;
    inst_ready = 1'b1;
    #1;
    chk("stray_valid", 0, inst_valid, 1'b0);
    chk("reissue_req", 0, imem_req,   1'b1);
    chk("reissue_addr", 0, imem_addr, 32'h0);
    repeat (5) @(negedge clk);
    inst_ready = 1'b0;
    #1;
    chk("starve_valid", 0, inst_valid, 1'b0);
`ifdef FETCH_PERF_EN
    chk("perf_cnt", 0, perf_stall_cnt, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
